// File: rtl/gc_block_tracker_pkg.sv
// Shared types, default geometry and relocation-FSM state encoding for the GC block tracker.
package gc_block_tracker_pkg;

    localparam int NUM_BLK_DEF       = 64;
    localparam int PAGES_PER_BLK_DEF = 32;

    typedef logic [$clog2(NUM_BLK_DEF)-1:0]       block_t;
    typedef logic [$clog2(PAGES_PER_BLK_DEF)-1:0] page_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        MOVE_WAIT,
        DONE
    } gc_move_state_t;

endpackage

// File: rtl/gc_block_tracker_move_fsm.sv
// Victim relocation sequencer: walks the victim's pages and issues one copy request per valid page.
module gc_block_tracker_move_fsm
    import gc_block_tracker_pkg::*;
#(
    parameter int BW            = 6,
    parameter int PW            = 5,
    parameter int PAGES_PER_BLK = 32
) (
    input  logic           clk,
    input  logic           srst,
    input  logic           move_flag,
    input  logic [BW-1:0]  erase_blk_num,
    input  logic           victim_bit,
    input  logic           active_full,
    input  logic           mv_ack,
    input  logic [PW-1:0]  dst_ptr,
    output gc_move_state_t state,
    output logic [BW-1:0]  victim,
    output logic [PW-1:0]  idx,
    output logic           mv_req,
    output logic [PW-1:0]  mv_src_page,
    output logic [PW-1:0]  mv_dst_page,
    output logic           move_done_flag
);

    localparam logic [PW-1:0] LAST_PAGE = PW'(PAGES_PER_BLK - 1);

    logic move_flag_prev;

    always_ff @(posedge clk) begin
        if (srst) begin
            state          <= IDLE;
            victim         <= '0;
            idx            <= '0;
            mv_req         <= 1'b0;
            mv_src_page    <= '0;
            mv_dst_page    <= '0;
            move_done_flag <= 1'b0;
            move_flag_prev <= 1'b0;
        end else begin
            move_flag_prev <= move_flag;
            move_done_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (move_flag && !move_flag_prev) begin
                        victim <= erase_blk_num;
                        idx    <= '0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    // A valid page with no room in the active block stalls here until GC supplies a new one
                    if (victim_bit) begin
                        if (!active_full) begin
                            mv_req      <= 1'b1;
                            mv_src_page <= idx;
                            mv_dst_page <= dst_ptr;
                            state       <= MOVE_WAIT;
                        end
                    end else if (idx == LAST_PAGE) begin
                        state          <= DONE;
                        move_done_flag <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                MOVE_WAIT: begin
                    if (mv_ack) begin
                        mv_req <= 1'b0;
                        if (idx == LAST_PAGE) begin
                            state          <= DONE;
                            move_done_flag <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gc_block_tracker.sv
// Per-block valid-page bitmap/count tracker with active-block write pointer and GC relocation.
// Optional macro GC_STATS_EN adds moved_pages_total / blocks_reclaimed saturating counters.
module gc_block_tracker
    import gc_block_tracker_pkg::*;
#(
    parameter int NUM_BLK       = NUM_BLK_DEF,
    parameter int PAGES_PER_BLK = PAGES_PER_BLK_DEF,
    localparam int BW = $clog2(NUM_BLK),
    localparam int PW = $clog2(PAGES_PER_BLK),
    localparam int CW = PW + 1
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [BW-1:0] wr_blk,
    output logic [PW-1:0] wr_page,
    input  logic          inv_valid,
    input  logic [BW-1:0] inv_blk,
    input  logic [PW-1:0] inv_page,
    input  logic [BW-1:0] active_blk_num,
    input  logic [BW-1:0] erase_blk_num,
    input  logic          move_flag,
    output logic          mv_req,
    output logic [PW-1:0] mv_src_page,
    output logic [PW-1:0] mv_dst_page,
    input  logic          mv_ack,
    output logic [BW-1:0] invalid_blk_num,
    output logic          invalid_flag,
    output logic          new_active_request,
    output logic          move_done_flag
`ifdef GC_STATS_EN
    ,
    output logic [31:0]   moved_pages_total,
    output logic [15:0]   blocks_reclaimed
`endif
);

    logic [PAGES_PER_BLK-1:0] bitmap_reg  [NUM_BLK];
    logic [PAGES_PER_BLK-1:0] bitmap_next [NUM_BLK];
    logic [CW-1:0]            count_reg   [NUM_BLK];
    logic [CW-1:0]            count_next  [NUM_BLK];

    logic [BW-1:0]  active_reg;
    logic [CW-1:0]  wr_ptr_reg;
    gc_move_state_t fsm_state;
    logic [BW-1:0]  victim;
    logic [PW-1:0]  scan_idx;
    logic           active_change, full, wr_fire, ack_fire, done_clear, inv_zero;

    assign active_change      = active_blk_num != active_reg;
    assign full               = wr_ptr_reg == CW'(PAGES_PER_BLK);
    assign wr_ready           = !full && (fsm_state == IDLE);
    assign wr_fire            = wr_valid && wr_ready;
    assign ack_fire           = (fsm_state == MOVE_WAIT) && mv_ack;
    assign done_clear         = fsm_state == DONE;
    assign new_active_request = full && !active_change;

    // Only a real 1->0 count transition reports, so duplicate invalidates stay silent
    assign inv_zero = inv_valid && (count_reg[inv_blk] != '0) && (count_next[inv_blk] == '0)
                      && (inv_blk != active_reg) && !((fsm_state != IDLE) && (inv_blk == victim));

    gc_block_tracker_move_fsm #(.BW(BW), .PW(PW), .PAGES_PER_BLK(PAGES_PER_BLK)) u_move_fsm (
        .clk            (CLK),
        .srst           (rst),
        .move_flag      (move_flag),
        .erase_blk_num  (erase_blk_num),
        .victim_bit     (bitmap_reg[victim][scan_idx]),
        .active_full    (full),
        .mv_ack         (mv_ack),
        .dst_ptr        (wr_ptr_reg[PW-1:0]),
        .state          (fsm_state),
        .victim         (victim),
        .idx            (scan_idx),
        .mv_req         (mv_req),
        .mv_src_page    (mv_src_page),
        .mv_dst_page    (mv_dst_page),
        .move_done_flag (move_done_flag)
    );

    generate
        for (genvar gi = 0; gi < NUM_BLK; gi++) begin : g_blk
            logic [PAGES_PER_BLK-1:0] set_mask, clr_mask;
            logic                     is_active, is_victim;

            assign is_active = active_reg == BW'(gi);
            assign is_victim = victim == BW'(gi);

            always_comb begin
                set_mask = '0;
                clr_mask = '0;
                if ((wr_fire || ack_fire) && is_active) set_mask[wr_ptr_reg[PW-1:0]] = 1'b1;
                if (inv_valid && (inv_blk == BW'(gi)))  clr_mask[inv_page]           = 1'b1;
                if (ack_fire && is_victim)              clr_mask[mv_src_page]        = 1'b1;
            end

            // Set after clear: a program to the same page as a same-cycle invalidate keeps the bit
            assign bitmap_next[gi] = (done_clear && is_victim) ? '0
                                   : ((bitmap_reg[gi] & ~clr_mask) | set_mask);
            assign count_next[gi]  = CW'($countones(bitmap_next[gi]));

            always_ff @(posedge CLK) begin
                if (rst) begin
                    bitmap_reg[gi] <= '0;
                    count_reg[gi]  <= '0;
                end else begin
                    bitmap_reg[gi] <= bitmap_next[gi];
                    count_reg[gi]  <= count_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (rst) begin
            active_reg      <= active_blk_num;
            wr_ptr_reg      <= '0;
            wr_blk          <= '0;
            wr_page         <= '0;
            invalid_flag    <= 1'b0;
            invalid_blk_num <= '0;
        end else begin
            if (active_change) begin
                active_reg <= active_blk_num;
                wr_ptr_reg <= '0;
            end else if (done_clear && (victim == active_reg)) begin
                wr_ptr_reg <= '0;
            end else if (wr_fire || ack_fire) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (wr_fire) begin
                wr_blk  <= active_reg;
                wr_page <= wr_ptr_reg[PW-1:0];
            end
            invalid_flag <= inv_zero;
            if (inv_zero) invalid_blk_num <= inv_blk;
        end
    end

`ifdef GC_STATS_EN
    always_ff @(posedge CLK) begin
        if (rst) begin
            moved_pages_total <= '0;
            blocks_reclaimed  <= '0;
        end else begin
            if (ack_fire && (moved_pages_total != '1)) moved_pages_total <= moved_pages_total + 1'b1;
            if (done_clear && (blocks_reclaimed != '1)) blocks_reclaimed <= blocks_reclaimed + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gc_block_tracker.sv
// Directed, table-driven bench for gc_block_tracker (GC_STATS_EN adds statistics checks).
module tb_gc_block_tracker;
    import gc_block_tracker_pkg::*;

    logic   CLK = 1'b0;
    logic   rst, wr_valid, inv_valid, move_flag, mv_ack;
    block_t inv_blk, active_blk_num, erase_blk_num;
    page_t  inv_page;
    logic   wr_ready, mv_req, invalid_flag, new_active_request, move_done_flag;
    block_t wr_blk, invalid_blk_num;
    page_t  wr_page, mv_src_page, mv_dst_page;
`ifdef GC_STATS_EN
    logic [31:0] moved_pages_total;
    logic [15:0] blocks_reclaimed;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    gc_block_tracker dut (
        .CLK(CLK), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_blk(wr_blk), .wr_page(wr_page),
        .inv_valid(inv_valid), .inv_blk(inv_blk), .inv_page(inv_page),
        .active_blk_num(active_blk_num), .erase_blk_num(erase_blk_num), .move_flag(move_flag),
        .mv_req(mv_req), .mv_src_page(mv_src_page), .mv_dst_page(mv_dst_page), .mv_ack(mv_ack),
        .invalid_blk_num(invalid_blk_num), .invalid_flag(invalid_flag),
        .new_active_request(new_active_request), .move_done_flag(move_done_flag)
`ifdef GC_STATS_EN
        , .moved_pages_total(moved_pages_total), .blocks_reclaimed(blocks_reclaimed)
`endif
    );

    typedef struct {
        logic   wr;
        logic   inv;
        block_t iblk;
        page_t  ipage;
        block_t act;
        block_t e_blk;
        page_t  e_page;
        logic   e_flag;
        block_t e_iblk;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic wr, logic inv, int iblk, int ipage, int act,
                                int e_blk, int e_page, logic e_flag, int e_iblk);
        vec_t v;
        v.wr = wr; v.inv = inv; v.iblk = block_t'(iblk); v.ipage = page_t'(ipage);
        v.act = block_t'(act); v.e_blk = block_t'(e_blk); v.e_page = page_t'(e_page);
        v.e_flag = e_flag; v.e_iblk = block_t'(e_iblk);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        wr_valid  = 1'b0;
        inv_valid = 1'b0;
    endtask

    task automatic do_reset(input int act);
        rst = 1'b1; move_flag = 1'b0; mv_ack = 1'b0; wr_valid = 1'b0; inv_valid = 1'b0;
        active_blk_num = block_t'(act); erase_blk_num = '0; inv_blk = '0; inv_page = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic write_one(input int eb, input int ep, input string nm);
        wr_valid = 1'b1;
        step();
        chk({nm, "_blk"}, 32'(wr_blk), 32'(eb));
        chk({nm, "_page"}, 32'(wr_page), 32'(ep));
        $display("write blk=%0d page=%0d", wr_blk, wr_page);
    endtask

    task automatic invalidate(input int b, input int p, input logic e_flag, input string nm);
        inv_valid = 1'b1; inv_blk = block_t'(b); inv_page = page_t'(p);
        step();
        chk(nm, 32'(invalid_flag), 32'(e_flag));
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!mv_req && n < 100) begin
            step();
            n++;
        end
        chk({nm, "_req_timeout"}, 32'(mv_req), 32'd1);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!move_done_flag && n < 100) begin
            step();
            n++;
        end
        chk({nm, "_done_timeout"}, 32'(move_done_flag), 32'd1);
        step();
        chk({nm, "_done_pulse"}, 32'(move_done_flag), 32'd0);
    endtask

    task automatic move_page(input int src, input int dst, input string nm);
        wait_req(nm);
        chk({nm, "_src"}, 32'(mv_src_page), 32'(src));
        chk({nm, "_dst"}, 32'(mv_dst_page), 32'(dst));
        step();
        chk({nm, "_hold1"}, 32'(mv_req), 32'd1);
        step();
        chk({nm, "_hold2"}, 32'(mv_req), 32'd1);
        mv_ack = 1'b1;
        step();
        mv_ack = 1'b0;
        $display("move src=%0d dst=%0d acked", src, dst);
    endtask

    initial begin
        //                wr inv iblk ipg act  eblk epg flag eiblk
        vecs[0]  = mk(1, 0, 0, 0, 4,  4, 1, 0, 3);
        vecs[1]  = mk(1, 0, 0, 0, 4,  4, 2, 0, 3);
        vecs[2]  = mk(0, 0, 0, 0, 5,  4, 2, 0, 3);
        vecs[3]  = mk(1, 0, 0, 0, 5,  5, 0, 0, 3);
        vecs[4]  = mk(1, 1, 4, 0, 5,  5, 1, 0, 3);
        vecs[5]  = mk(0, 1, 4, 1, 5,  5, 1, 0, 3);
        vecs[6]  = mk(0, 1, 4, 2, 5,  5, 1, 1, 4);
        vecs[7]  = mk(0, 1, 4, 2, 5,  5, 1, 0, 4);
        vecs[8]  = mk(0, 1, 5, 0, 5,  5, 1, 0, 4);
        vecs[9]  = mk(0, 1, 5, 1, 5,  5, 1, 0, 4);
        vecs[10] = mk(1, 1, 5, 2, 5,  5, 2, 0, 4);
        vecs[11] = mk(0, 0, 0, 0, 6,  5, 2, 0, 4);
        vecs[12] = mk(0, 1, 5, 2, 6,  5, 2, 1, 5);
        vecs[13] = mk(1, 0, 0, 0, 6,  6, 0, 0, 5);

        // Reset and fill block 3
        do_reset(3);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_nar", 32'(new_active_request), 32'd0);
        chk("rst_mv_req", 32'(mv_req), 32'd0);
        chk("rst_inv_flag", 32'(invalid_flag), 32'd0);
        chk("rst_done", 32'(move_done_flag), 32'd0);
        chk("rst_wr_blk", 32'(wr_blk), 32'd0);
        for (int p = 0; p < 32; p++) write_one(3, p, "fill3");
        chk("full_nar", 32'(new_active_request), 32'd1);
        chk("full_ready", 32'(wr_ready), 32'd0);
        active_blk_num = 4;
        #1;
        chk("chg_nar_drop", 32'(new_active_request), 32'd0);
        step();
        chk("chg_ready", 32'(wr_ready), 32'd1);
        write_one(4, 0, "new_active");

        // Invalidate every page of block 3, then a duplicate
        for (int p = 0; p < 32; p++) invalidate(3, p, p == 31, "inv3_flag");
        chk("inv3_blk", 32'(invalid_blk_num), 32'd3);
        step();
        chk("inv3_pulse", 32'(invalid_flag), 32'd0);
        invalidate(3, 5, 1'b0, "inv3_dup");

        // Table: writes, invalidates, active changes, write-wins collision
        for (int i = 0; i < 14; i++) begin
            wr_valid = vecs[i].wr; inv_valid = vecs[i].inv; inv_blk = vecs[i].iblk;
            inv_page = vecs[i].ipage; active_blk_num = vecs[i].act;
            step();
            chk($sformatf("vec%0d_wr_blk", i), 32'(wr_blk), 32'(vecs[i].e_blk));
            chk($sformatf("vec%0d_wr_page", i), 32'(wr_page), 32'(vecs[i].e_page));
            chk($sformatf("vec%0d_inv_flag", i), 32'(invalid_flag), 32'(vecs[i].e_flag));
            chk($sformatf("vec%0d_inv_blk", i), 32'(invalid_blk_num), 32'(vecs[i].e_iblk));
            $display("vec %0d wr=%0d/%0d inv_flag=%0b inv_blk=%0d", i, wr_blk, wr_page,
                     invalid_flag, invalid_blk_num);
        end

        // Relocate block 3 pages {2,7,30} into block 4
        do_reset(3);
        for (int p = 0; p < 31; p++) write_one(3, p, "setup3");
        for (int p = 0; p < 31; p++)
            if (p != 2 && p != 7 && p != 30) invalidate(3, p, 1'b0, "setup3_inv");
        active_blk_num = 4;
        step();
        erase_blk_num = 3;
        move_flag = 1'b1;
        move_page(2, 0, "mv_a");
        move_page(7, 1, "mv_b");
        move_page(30, 2, "mv_c");
        wait_done("mv");
        move_flag = 1'b0;
        chk("mv_no_inv_flag", 32'(invalid_flag), 32'd0);
`ifdef GC_STATS_EN
        chk("stats_moved", moved_pages_total, 32'd3);
        chk("stats_reclaimed", 32'(blocks_reclaimed), 32'd1);
`endif
        invalidate(3, 2, 1'b0, "victim_cleared");
        active_blk_num = 5;
        step();
        invalidate(4, 0, 1'b0, "dst4_p0");
        invalidate(4, 1, 1'b0, "dst4_p1");
        invalidate(4, 2, 1'b1, "dst4_p2");
        chk("dst4_blk", 32'(invalid_blk_num), 32'd4);

        // Move stalls on a full active block until the active block changes
        do_reset(3);
        write_one(3, 0, "stall_src");
        write_one(3, 1, "stall_src");
        active_blk_num = 4;
        step();
        for (int p = 0; p < 31; p++) write_one(4, p, "stall_fill");
        erase_blk_num = 3;
        move_flag = 1'b1;
        move_page(0, 31, "stall_a");
        for (int i = 0; i < 4; i++) step();
        chk("stall_req", 32'(mv_req), 32'd0);
        chk("stall_nar", 32'(new_active_request), 32'd1);
        active_blk_num = 5;
        move_page(1, 0, "stall_b");
        wait_done("stall");
        move_flag = 1'b0;

        // Reset during MOVE_WAIT
        do_reset(3);
        write_one(3, 0, "rstmv_src");
        active_blk_num = 4;
        step();
        erase_blk_num = 3;
        move_flag = 1'b1;
        wait_req("rstmv");
        rst = 1'b1;
        move_flag = 1'b0;
        step();
        chk("rstmv_req", 32'(mv_req), 32'd0);
        rst = 1'b0;
        step();
        chk("rstmv_ready", 32'(wr_ready), 32'd1);
        invalidate(3, 0, 1'b0, "rstmv_cnt0");
        write_one(4, 0, "rstmv_wr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gc_block_tracker.md
Name: gc_block_tracker

Overview:
- Per-block page-validity tracker feeding the garbage-collection stage; implements the remapping-table side of `garbage_collection_if`.
- Keeps a valid-page bitmap and valid count per block, plus the write pointer of the active block.
- Reports fully-invalid blocks, requests a new active block when the current one fills, and relocates valid pages of the GC victim block on `move_flag`.

Parameters:
- NUM_BLK, 64, number of physical blocks; block_t is $clog2(NUM_BLK) bits.
- PAGES_PER_BLK, 32, pages per block; page_t is $clog2(PAGES_PER_BLK) bits.

Ports:
- CLK  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  host page program request into active block
- wr_ready  out  1  write accepted this cycle when wr_valid && wr_ready
- wr_blk  out  block_t  physical block of accepted write
- wr_page  out  page_t  physical page of accepted write
- inv_valid  in  1  a page became stale
- inv_blk  in  block_t  block of stale page
- inv_page  in  page_t  page of stale page
- active_blk_num  in  block_t  from GC: block to use as active block
- erase_blk_num  in  block_t  from GC: victim block
- move_flag  in  1  from GC: relocate victim's valid pages (level)
- mv_req  out  1  page copy request to flash datapath
- mv_src_page  out  page_t  source page in erase_blk_num
- mv_dst_page  out  page_t  destination page in active block
- mv_ack  in  1  copy complete
- invalid_blk_num  out  block_t  block that became fully invalid
- invalid_flag  out  1  one-cycle pulse qualifying invalid_blk_num
- new_active_request  out  1  active block full, level
- move_done_flag  out  1  one-cycle pulse, relocation finished

Behaviour:
- Reset: all bitmaps, counts, write pointers, and outputs 0. Active block latched = active_blk_num at reset, wr_ptr=0.
- Active-block change: each cycle, if active_blk_num != latched active, latch it and set wr_ptr=0. This also clears new_active_request the same cycle.
- Host write:
  - wr_ready = !full && state==IDLE, where full = (wr_ptr==PAGES_PER_BLK).
  - On accept: wr_blk/wr_page are registered, valid the next cycle. Set bit[active][wr_ptr], count++, wr_ptr++.
- new_active_request: asserted the cycle after wr_ptr reaches PAGES_PER_BLK; held until the active block changes.
- Invalidate:
  - Clear the bit. count-- only if the bit was set; a duplicate invalidate is ignored.
  - If the resulting count==0, the block is not the active block, and the block is not the erase_blk_num currently being moved: pulse invalid_flag next cycle with invalid_blk_num=inv_blk.
- Invalidate and write in the same cycle to the same page: the write wins.
- FSM states: IDLE, SCAN, MOVE_WAIT, DONE.
  - IDLE -> SCAN on move_flag rising edge. Page index i=0; victim latched from erase_blk_num.
  - SCAN:
    - If bit[victim][i] set and the active block is not full: assert mv_req, src=i, dst=wr_ptr; -> MOVE_WAIT.
    - If bit[victim][i] set and the active block is full: stay in SCAN (new_active_request asserted) until the active block changes.
    - If bit clear: i++. After i==PAGES_PER_BLK-1 -> DONE.
  - MOVE_WAIT: mv_req held until mv_ack. On ack: set dst bit, count[active]++, wr_ptr++, clear src bit, count[victim]--, i++; -> SCAN, or DONE if i was the last page.
  - DONE: victim bitmap, count, and wr_ptr cleared (block is free). Pulse move_done_flag for one cycle; -> IDLE.
- An invalidate during a move to a page being moved: if before mv_ack, clear the source bit. At mv_ack the destination is still set; the upstream remap owns consistency, and this block accepts it.
- Counts are $clog2(PAGES_PER_BLK)+1 bits, never below 0 or above PAGES_PER_BLK.
- Reset mid-move: immediate return to IDLE, all state cleared, mv_req deasserted.

Optional Feature:
- GC_STATS_EN.
- Defined: adds outputs moved_pages_total (32b) and blocks_reclaimed (16b). They increment per mv_ack and per DONE respectively, saturate at max, and clear on rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- NVM_pkg: block_t, page_t, NUM_BLK/PAGES_PER_BLK defaults, gc_move_state_t enum.
- One sub-module: gc_move_fsm (SCAN/MOVE_WAIT/DONE sequencing, page index). Bitmap/count storage stays in top.

Test Plan:
- Reset, active=3; 32 writes -> wr_page 0..31 in block 3; cycle after 32nd, new_active_request=1 and wr_ready=0. Set active_blk_num=4 -> request drops, next write returns blk4 page0.
- Fill block 3; invalidate its 32 pages -> single invalid_flag pulse with invalid_blk_num=3 after the 32nd; duplicate invalidate of page 5 -> no count change, no pulse.
- Block 3 valid pages {2,7,30}, active=4 wr_ptr=0; erase=3, raise move_flag -> mv_req src 2/7/30 with dst 0/1/2, acked after 3 cycles each; then move_done_flag pulse; block 3 count 0, no invalid_flag.
- Move with active block full at 1 free page and 2 valid pages -> second move stalls with new_active_request=1; active change -> dst page 0 of new block.
- rst asserted during MOVE_WAIT -> next cycle mv_req=0, all counts 0, state IDLE.
- GC_STATS_EN defined: previous move scenario -> moved_pages_total=3, blocks_reclaimed=1.
